// File: rtl/spi_master_if.sv
// Bus bundle between the SPI master and the control logic that drives it.
// Holds the byte handshake and the SPI pin signals. Signal names are seen
// from the master's side: i_* flow into the master, o_* flow out of it.
interface spi_master_if;
    logic [7:0] i_TX_Byte;
    logic       i_TX_DV;
    logic       o_TX_Ready;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       o_SPI_Clk;
    logic       i_SPI_MISO;
    logic       o_SPI_MOSI;

    modport master (
        input  i_TX_Byte,
        input  i_TX_DV,
        input  i_SPI_MISO,
        output o_TX_Ready,
        output o_RX_DV,
        output o_RX_Byte,
        output o_SPI_Clk,
        output o_SPI_MOSI
    );

    modport slave (
        output i_TX_Byte,
        output i_TX_DV,
        output i_SPI_MISO,
        input  o_TX_Ready,
        input  o_RX_DV,
        input  o_RX_Byte,
        input  o_SPI_Clk,
        input  o_SPI_MOSI
    );
endinterface

// File: rtl/spi_master.sv
// Byte-oriented SPI master. One byte per accepted strobe is shifted out MSB
// first while eight bits are captured from MISO. The received byte is then
// presented with a one-cycle valid pulse. Chip-select is handled outside.
// i_Rst_L is an active-high asynchronous reset, despite its name.
module spi_master #(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic          i_Clk,
    input  logic          i_Rst_L,
    spi_master_if.master  bus
);

    localparam logic [1:0] MODE_BITS = 2'(SPI_MODE);
    localparam logic       CPOL      = MODE_BITS[1];
    localparam logic       CPHA      = MODE_BITS[0];
    localparam int         HW        = $clog2(CLKS_PER_HALF_BIT);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q;
    logic [HW-1:0]   half_cnt_q;
    logic [4:0]      edge_cnt_q;
    logic [7:0]      tx_q;
    logic [7:0]      rx_q;
    logic            ready_q;
    logic            rx_dv_q;
    logic [7:0]      rx_byte_q;
    logic            spi_clk_q;
    logic            mosi_q;

    logic            wrap_d;
    logic            lead_d;
    logic            trail_d;
    logic            last_d;
    logic            sample_d;
    logic [7:0]      rx_d;

    // Decode which SPI edge (if any) the current half-bit wrap produces and
    // the receive shift value including a bit sampled on this edge.
    always_comb begin
        wrap_d   = (state_q == BUSY) && (half_cnt_q == HALF_LAST);
        // Edge counter starts at 16, so an even count marks a leading edge.
        lead_d   = wrap_d && !edge_cnt_q[0];
        trail_d  = wrap_d &&  edge_cnt_q[0];
        last_d   = wrap_d && (edge_cnt_q == 5'd1);
        sample_d = CPHA ? trail_d : lead_d;
        rx_d     = sample_d ? {rx_q[6:0], bus.i_SPI_MISO} : rx_q;
    end

    // Transfer FSM: accepts a strobe in IDLE, paces the SPI clock in BUSY,
    // shifts MOSI/MISO on the phase-appropriate edges and posts the result.
    always_ff @(posedge i_Clk or posedge i_Rst_L) begin
        if (i_Rst_L) begin
            state_q    <= IDLE;
            half_cnt_q <= '0;
            edge_cnt_q <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            ready_q    <= 1'b1;
            rx_dv_q    <= 1'b0;
            rx_byte_q  <= '0;
            spi_clk_q  <= CPOL;
            mosi_q     <= 1'b0;
        end else begin
            rx_dv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_TX_DV) begin
                        state_q    <= BUSY;
                        ready_q    <= 1'b0;
                        tx_q       <= bus.i_TX_Byte;
                        edge_cnt_q <= 5'd16;
                        half_cnt_q <= '0;
                        rx_q       <= '0;
                        // With CPHA=0 the first bit must be valid before the
                        // first clock edge, so present it right away.
                        if (!CPHA) begin
                            mosi_q <= bus.i_TX_Byte[7];
                        end
                    end
                end
                BUSY: begin
                    half_cnt_q <= wrap_d ? '0 : half_cnt_q + HW'(1);
                    if (wrap_d) begin
                        spi_clk_q  <= ~spi_clk_q;
                        edge_cnt_q <= edge_cnt_q - 5'd1;
                        rx_q       <= rx_d;
                    end
                    if (CPHA) begin
                        if (lead_d) begin
                            mosi_q <= tx_q[7];
                            tx_q   <= {tx_q[6:0], 1'b0};
                        end
                    end else begin
                        // Bit 7 went out at acceptance; each trailing edge
                        // but the final one moves on to the next bit.
                        if (trail_d && !last_d) begin
                            mosi_q <= tx_q[6];
                            tx_q   <= {tx_q[6:0], 1'b0};
                        end
                    end
                    if (last_d) begin
                        state_q   <= IDLE;
                        ready_q   <= 1'b1;
                        rx_dv_q   <= 1'b1;
                        rx_byte_q <= rx_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_TX_Ready = ready_q;
    assign bus.o_RX_DV    = rx_dv_q;
    assign bus.o_RX_Byte  = rx_byte_q;
    assign bus.o_SPI_Clk  = spi_clk_q;
    assign bus.o_SPI_MOSI = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: four instances cover modes 3/0 (MISO looped back to
// MOSI) and modes 1/2 (MISO from a small slave model returning 0x5A).
// Stimulus pushes expected bytes into a scoreboard; a monitor pops them on
// every o_RX_DV.
`timescale 1ns/1ps
module tb_spi_master;

    // Per-instance configuration, instance 0 in the low bits.
    localparam logic [7:0]  MODES = {2'd2, 2'd1, 2'd0, 2'd3};
    localparam logic [15:0] CLKS  = {4'd2, 4'd3, 4'd2, 4'd4};

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_byte [4];
    logic [3:0] tx_dv;
    logic [3:0] rdy, rxdv, sclk, mosi;
    logic [3:0] model_miso;
    logic [7:0] rxb [4];
    logic [7:0] slave_byte;
    logic [7:0] mosi_rec, mosi_last;
    int         rx_count [4];
    exp_t       exp_q [$];
    int         n_vec = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic cpol(input int i);
        return MODES[2*i+1];
    endfunction

    function automatic logic cpha(input int i);
        return MODES[2*i];
    endfunction

    function automatic int clks(input int i);
        return int'(CLKS[4*i +: 4]);
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_master_if bus ();
        assign bus.i_TX_Byte  = tx_byte[g];
        assign bus.i_TX_DV    = tx_dv[g];
        assign bus.i_SPI_MISO = (g < 2) ? bus.o_SPI_MOSI : model_miso[g];
        assign rdy[g]  = bus.o_TX_Ready;
        assign rxdv[g] = bus.o_RX_DV;
        assign rxb[g]  = bus.o_RX_Byte;
        assign sclk[g] = bus.o_SPI_Clk;
        assign mosi[g] = bus.o_SPI_MOSI;
        spi_master #(
            .SPI_MODE          (int'(MODES[2*g +: 2])),
            .CLKS_PER_HALF_BIT (int'(CLKS[4*g +: 4]))
        ) u_dut (
            .i_Clk   (clk),
            .i_Rst_L (rst),
            .bus     (bus.master)
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Slave model for instances 2 and 3: shifts slave_byte out MSB first,
    // changing data on the edge opposite to the one the master samples.
    initial begin : slave_model
        logic [7:0] sh [4];
        logic [3:0] prev;
        model_miso = '0;
        prev       = {cpol(3), cpol(2), cpol(1), cpol(0)};
        for (int i = 0; i < 4; i++) sh[i] = '0;
        forever begin
            @(negedge clk);
            for (int i = 2; i < 4; i++) begin
                if (rdy[i] === 1'b1) begin
                    sh[i]         = slave_byte;
                    model_miso[i] = cpha(i) ? 1'b0 : slave_byte[7];
                end else if (sclk[i] !== prev[i]) begin
                    if (sclk[i] !== cpol(i)) begin
                        if (cpha(i)) begin
                            model_miso[i] = sh[i][7];
                            sh[i]         = {sh[i][6:0], 1'b0};
                        end
                    end else if (!cpha(i)) begin
                        sh[i]         = {sh[i][6:0], 1'b0};
                        model_miso[i] = sh[i][7];
                    end
                end
                prev[i] = sclk[i];
            end
        end
    end

    // Monitor: pops the scoreboard on every o_RX_DV and records instance 0's
    // MOSI on rising SPI clock edges.
    initial begin : monitor
        exp_t e;
        logic sclk0_prev;
        sclk0_prev = 1'b1;
        mosi_rec   = '0;
        mosi_last  = '0;
        for (int i = 0; i < 4; i++) rx_count[i] = 0;
        forever begin
            @(negedge clk);
            if (rst) mosi_rec = '0;
            else if (sclk[0] && !sclk0_prev) mosi_rec = {mosi_rec[6:0], mosi[0]};
            sclk0_prev = sclk[0];
            for (int i = 0; i < 4; i++) begin
                if (rxdv[i] === 1'b1) begin
                    rx_count[i]++;
                    if (i == 0) begin
                        mosi_last = mosi_rec;
                        mosi_rec  = '0;
                    end
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_rx_dv: instance %0d got byte 0x%0h, required no strobe", i, rxb[i]);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_instance", 32'(i), 32'(e.idx));
                        check("rx_byte", 32'(rxb[i]), 32'(e.data));
                    end
                end
            end
        end
    end

    task automatic start(input int i, input logic [7:0] b, input logic [7:0] exp_rx, input bit expect_rx);
        tx_byte[i] = b;
        tx_dv[i]   = 1'b1;
        if (expect_rx) exp_q.push_back('{idx: 2'(i), data: exp_rx});
    endtask

    // Drops the strobe, checks acceptance, counts busy cycles and checks the
    // completion cycle. Optionally injects a stray strobe mid-transfer.
    task automatic finish(input int i, input logic [7:0] b, input string tag, input bit inject);
        int cnt;
        @(negedge clk);
        tx_dv[i] = 1'b0;
        check({tag, "_accepted"}, 32'(rdy[i]), 32'd0);
        check({tag, "_rx_dv_idle"}, 32'(rxdv[i]), 32'd0);
        if (!cpha(i)) check({tag, "_mosi_first_bit"}, 32'(mosi[i]), 32'(b[7]));
        cnt = 0;
        while (rdy[i] !== 1'b1 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
            if (inject && cnt == 10) begin
                tx_byte[i] = 8'hFF;
                tx_dv[i]   = 1'b1;
            end
            if (inject && cnt == 11) tx_dv[i] = 1'b0;
        end
        check({tag, "_busy_cycles"}, 32'(cnt), 32'(16 * clks(i)));
        check({tag, "_rx_dv_with_ready"}, 32'(rxdv[i]), 32'd1);
        check({tag, "_clk_idle_after"}, 32'(sclk[i]), 32'(cpol(i)));
    endtask

    initial begin : stimulus
        int base;
        int e;
        logic p;
        for (int i = 0; i < 4; i++) tx_byte[i] = '0;
        tx_dv      = '0;
        slave_byte = 8'h5A;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("reset_ready", 32'(rdy[i]), 32'd1);
            check("reset_rx_dv", 32'(rxdv[i]), 32'd0);
            check("reset_rx_byte", 32'(rxb[i]), 32'd0);
            check("reset_spi_clk", 32'(sclk[i]), 32'(cpol(i)));
            check("reset_mosi", 32'(mosi[i]), 32'd0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Mode 3, C=4, loopback: 0xC3 then 0xAA back-to-back.
        check("m3_clk_idle_before", 32'(sclk[0]), 32'd1);
        start(0, 8'hC3, 8'hC3, 1'b1);
        finish(0, 8'hC3, "m3_c3", 1'b0);
        start(0, 8'hAA, 8'hAA, 1'b1);
        finish(0, 8'hAA, "m3_aa", 1'b0);
        @(negedge clk);
        check("m3_mosi_on_rising", 32'(mosi_last), 32'h0000_00AA);
        check("m3_rx_dv_one_cycle", 32'(rxdv[0]), 32'd0);
        check("m3_rx_byte_hold", 32'(rxb[0]), 32'h0000_00AA);

        // Mode 0, C=2, loopback.
        start(1, 8'h81, 8'h81, 1'b1);
        finish(1, 8'h81, "m0_81", 1'b0);
        @(negedge clk);

        // Modes 1 and 2 against the slave model.
        start(2, 8'h0F, 8'h5A, 1'b1);
        finish(2, 8'h0F, "m1_5a", 1'b0);
        @(negedge clk);
        start(3, 8'hF0, 8'h5A, 1'b1);
        finish(3, 8'hF0, "m2_5a", 1'b0);
        @(negedge clk);

        // Stray strobe with 0xFF while 0x3C is shifting.
        base = rx_count[1];
        start(1, 8'h3C, 8'h3C, 1'b1);
        finish(1, 8'h3C, "m0_strobe", 1'b1);
        repeat (40) @(negedge clk);
        check("m0_strobe_single_rx_dv", 32'(rx_count[1] - base), 32'd1);

        // Reset after the 7th SPI edge of a mode 3 transfer.
        base = rx_count[0];
        start(0, 8'h96, 8'h00, 1'b0);
        @(negedge clk);
        tx_dv[0] = 1'b0;
        e = 0;
        p = sclk[0];
        for (int k = 0; k < 400 && e < 7; k++) begin
            @(negedge clk);
            if (sclk[0] !== p) e++;
            p = sclk[0];
        end
        check("abort_edges_seen", 32'(e), 32'd7);
        rst = 1'b1;
        #1;
        check("abort_ready", 32'(rdy[0]), 32'd1);
        check("abort_rx_dv", 32'(rxdv[0]), 32'd0);
        check("abort_rx_byte", 32'(rxb[0]), 32'd0);
        check("abort_spi_clk", 32'(sclk[0]), 32'd1);
        check("abort_mosi", 32'(mosi[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (70) @(negedge clk);
        check("abort_no_rx_dv", 32'(rx_count[0] - base), 32'd0);
        start(0, 8'h55, 8'h55, 1'b1);
        finish(0, 8'h55, "post_abort_55", 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
